// File: rtl/key_debounce_bank_if.sv
// rtl/key_debounce_bank_if.sv - key pin and debounced-event bundle for key_debounce_bank
//
// Purpose: groups the raw key pins and the per-channel debounced outputs
//   of key_debounce_bank into one bundle.
// Signals (each N_KEYS wide):
//   key            raw asynchronous key pins
//   key_level      debounced pressed level, 1 = pressed
//   press_pulse    1-cycle strobe on debounced press
//   release_pulse  1-cycle strobe on debounced release
//   toggle         flips on each debounced release
//   long_pulse     1-cycle strobe when a press is held long enough
// Modports:
//   master  debouncer side (takes key, drives the event outputs)
//   slave   pin/consumer side (drives key, observes the event outputs)
interface key_debounce_bank_if #(
  parameter int N_KEYS = 2
);
  logic [N_KEYS-1:0] key;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] toggle;
  logic [N_KEYS-1:0] long_pulse;

  modport master (
    input  key,
    output key_level, press_pulse, release_pulse, toggle, long_pulse
  );

  modport slave (
    output key,
    input  key_level, press_pulse, release_pulse, toggle, long_pulse
  );
endinterface

// File: rtl/key_debounce_bank.sv
// rtl/key_debounce_bank.sv - multi-channel push-button debouncer with press/release/toggle/long-press events
//
// Purpose: each channel synchronises one raw key pin, rejects bounce shorter
//   than DEB_CYCLES synchronised samples and reports a debounced level,
//   press/release strobes and a toggle bit. Channels are fully independent.
// Ports:
//   SYSCLK  in  system clock, all logic on rising edge
//   RST_N   in  asynchronous active-low reset
//   bus     key_debounce_bank_if.master: key in; key_level, press_pulse,
//           release_pulse, toggle, long_pulse out (all registered)
// Build option:
//   LONG_PRESS_EN  when defined, a per-channel hold counter issues one
//                  long_pulse after LONG_CYCLES in HELD; otherwise long_pulse = 0.
module key_debounce_bank #(
  parameter int N_KEYS         = 2,
  parameter int DEB_CYCLES     = 1000000,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int TOGGLE_INIT    = 0,
  parameter int LONG_CYCLES    = 100000000
) (
  input  logic                 SYSCLK,
  input  logic                 RST_N,
  key_debounce_bank_if.master  bus
);

  localparam int MAX_CYCLES = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic          TOG_INIT = (TOGGLE_INIT != 0);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_HELD         = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  logic [N_KEYS-1:0] pin_pressed;
  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;

  logic [1:0]        state_q [N_KEYS];
  logic [CW-1:0]     cnt_q   [N_KEYS];
  logic [N_KEYS-1:0] level_q;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] release_q;
  logic [N_KEYS-1:0] toggle_q;

`ifdef LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_C    = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  logic [CW-1:0]     hold_q [N_KEYS];
  logic [N_KEYS-1:0] long_q;
`endif

  // Normalise polarity before synchronising so every flop below means "pressed".
  assign pin_pressed = (KEY_ACTIVE_LOW != 0) ? ~bus.key : bus.key;

  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pin_pressed;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
`ifdef LONG_PRESS_EN
        hold_q[i]  <= '0;
`endif
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      toggle_q  <= {N_KEYS{TOG_INIT}};
`ifdef LONG_PRESS_EN
      long_q    <= '0;
`endif
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        press_q[i]   <= 1'b0;
        release_q[i] <= 1'b0;
`ifdef LONG_PRESS_EN
        long_q[i]    <= 1'b0;
`endif
        case (state_q[i])
          S_IDLE: begin
            if (sync2_q[i]) begin
              state_q[i] <= S_PRESS_WAIT;
              cnt_q[i]   <= CNT_ONE;
            end
          end
          S_PRESS_WAIT: begin
            if (!sync2_q[i]) begin
              state_q[i] <= S_IDLE;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] >= DEB_LAST) begin
              // This sample is the DEB_CYCLES-th consecutive pressed one.
              state_q[i] <= S_HELD;
              cnt_q[i]   <= '0;
              level_q[i] <= 1'b1;
              press_q[i] <= 1'b1;
`ifdef LONG_PRESS_EN
              hold_q[i]  <= '0;
`endif
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end
          S_HELD: begin
            if (!sync2_q[i]) begin
              state_q[i] <= S_RELEASE_WAIT;
              cnt_q[i]   <= CNT_ONE;
            end
`ifdef LONG_PRESS_EN
            // Saturates at LONG_CYCLES so a single press yields one strobe.
            else if (hold_q[i] < LONG_C) begin
              hold_q[i] <= hold_q[i] + CNT_ONE;
              if (hold_q[i] == LONG_LAST)
                long_q[i] <= 1'b1;
            end
`endif
          end
          S_RELEASE_WAIT: begin
            if (sync2_q[i]) begin
              // Release bounce: back to HELD, hold counter keeps its progress.
              state_q[i] <= S_HELD;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] >= DEB_LAST) begin
              state_q[i]   <= S_IDLE;
              cnt_q[i]     <= '0;
              level_q[i]   <= 1'b0;
              release_q[i] <= 1'b1;
              toggle_q[i]  <= ~toggle_q[i];
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.key_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.toggle        = toggle_q;
`ifdef LONG_PRESS_EN
  assign bus.long_pulse    = long_q;
`else
  assign bus.long_pulse    = '0;
`endif

endmodule

// File: tb/tb_key_debounce_bank.sv
// tb/tb_key_debounce_bank.sv - scoreboard bench for key_debounce_bank
module tb_key_debounce_bank;
  localparam int NK   = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  // Drive just after edge k: sync stage 1 captures at k+1, strobe visible after edge k+1+DEB+1.
  localparam int LAT  = DEB + 2;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_LONG    = 2;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  logic SYSCLK = 1'b0;
  logic RST_N  = 1'b0;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [NK-1:0] exp_level = '0;
  logic [NK-1:0] exp_tog   = '0;
  ev_t  sb[$];

  key_debounce_bank_if #(.N_KEYS(NK)) bus ();

  key_debounce_bank #(
    .N_KEYS(NK),
    .DEB_CYCLES(DEB),
    .KEY_ACTIVE_LOW(1),
    .TOGGLE_INIT(0),
    .LONG_CYCLES(LONG)
  ) dut (
    .SYSCLK(SYSCLK),
    .RST_N(RST_N),
    .bus(bus)
  );

  always #5 SYSCLK = ~SYSCLK;
  always @(posedge SYSCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge SYSCLK);
      #1;
    end
  endtask

  task automatic expect_ev(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic press(input int ch);
    bus.key[ch] = 1'b0;
    expect_ev(cyc + LAT, ch, EV_PRESS);
    exp_level[ch] = 1'b1;
  endtask

  task automatic release_key(input int ch);
    bus.key[ch] = 1'b1;
    expect_ev(cyc + LAT, ch, EV_RELEASE);
    exp_level[ch] = 1'b0;
    exp_tog[ch]   = ~exp_tog[ch];
  endtask

  task automatic check_state(input string tag);
    check({tag, "_level"}, int'(bus.key_level), int'(exp_level));
    check({tag, "_toggle"}, int'(bus.toggle), int'(exp_tog));
  endtask

  // Every observed strobe is matched against the oldest expected event.
  always @(negedge SYSCLK) begin
    ev_t e;
    logic [2:0] pl;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("missed_event_cyc", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    for (int ch = 0; ch < NK; ch++) begin
      pl = {bus.long_pulse[ch], bus.release_pulse[ch], bus.press_pulse[ch]};
      for (int k = 0; k < 3; k++) begin
        if (pl[k]) begin
          if (sb.size() > 0) begin
            e = sb.pop_front();
          end else begin
            e.cyc  = -1;
            e.ch   = -1;
            e.kind = -1;
          end
          check("ev_cyc", cyc, e.cyc);
          check("ev_ch", ch, e.ch);
          check("ev_kind", k, e.kind);
        end
      end
    end
  end

  initial begin
    bus.key = '1;
    RST_N   = 1'b0;
    step(3);
    check("rst_level", int'(bus.key_level), 0);
    check("rst_press", int'(bus.press_pulse), 0);
    check("rst_release", int'(bus.release_pulse), 0);
    check("rst_toggle", int'(bus.toggle), 0);
    check("rst_long", int'(bus.long_pulse), 0);
    RST_N = 1'b1;
    step(3);

    // Clean press then release on channel 0; channel 1 must stay quiet.
    press(0);
    step(10);
    check_state("t1_press");
    release_key(0);
    step(10);
    check_state("t3_release");

    // Bounce: never DEB_CYCLES consecutive pressed samples.
    repeat (10) begin
      bus.key[0] = 1'b0;
      step(3);
      bus.key[0] = 1'b1;
      step(1);
    end
    step(10);
    check_state("t2_bounce");

    // Reset at cnt=3 of PRESS_WAIT with the key held: progress discarded.
    bus.key[0] = 1'b0;
    step(5);
    RST_N = 1'b0;
    exp_level = '0;
    exp_tog   = '0;
    step(2);
    check_state("t4_in_reset");
    check("t4_press_in_reset", int'(bus.press_pulse), 0);
    RST_N = 1'b1;
    expect_ev(cyc + LAT, 0, EV_PRESS);
    exp_level[0] = 1'b1;
    step(10);
    check_state("t4_after_reset");
    release_key(0);
    step(10);
    check_state("t4_release");

    // Second press/release returns toggle to 0.
    press(0);
    step(10);
    release_key(0);
    step(10);
    check_state("t3_second");

    // Long press on channel 1.
    press(1);
`ifdef LONG_PRESS_EN
    expect_ev(cyc + LAT + LONG, 1, EV_LONG);
`endif
    step(40);
    check_state("t5_held");
    release_key(1);
    step(10);
    check_state("t5_release");

    // Simultaneous presses, independent releases.
    press(0);
    press(1);
    step(8);
    release_key(0);
    step(4);
    release_key(1);
    step(10);
    check_state("t6_final");

    step(5);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
